// File: rtl/sens_frame_parser_if.sv
// Byte-stream and memory-write bundle for the sensor frame parser.
// Handshake: byte_vld_i is a one-cycle strobe qualifying byte_i; there is no
// ready/backpressure, so the parser accepts a byte on every cycle the strobe is
// high. sens_write_data_o is likewise a one-cycle strobe qualifying
// sens_data_o/sens_addr_o towards the memory, which must accept it unconditionally.
interface sens_frame_parser_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              clk_en_i;
  logic [7:0]        byte_i;
  logic              byte_vld_i;
  logic [DATA_W-1:0] sens_data_o;
  logic [ADDR_W-1:0] sens_addr_o;
  logic              sens_write_data_o;
  logic              sat_o;
  logic              err_o;
  logic [7:0]        frame_cnt_o;
  logic [1:0]        state_dbg_o;

  modport master (
    output clk_en_i, byte_i, byte_vld_i,
    input  sens_data_o, sens_addr_o, sens_write_data_o, sat_o, err_o,
           frame_cnt_o, state_dbg_o
  );

  modport slave (
    input  clk_en_i, byte_i, byte_vld_i,
    output sens_data_o, sens_addr_o, sens_write_data_o, sat_o, err_o,
           frame_cnt_o, state_dbg_o
  );
endinterface

// File: rtl/sens_frame_parser.sv
// Sensor frame decoder: parses "R" + 1..DIGITS ASCII decimal digits + terminator,
// converts the digits to a saturating binary value and issues one memory write per
// good frame. Reports framing errors and inter-byte timeouts as a one-cycle err_o.
module sens_frame_parser #(
  parameter int          DIGITS        = 3,
  parameter int          DATA_W        = 16,
  parameter int          ADDR_W        = 8,
  parameter int          MEM_ADDR      = 13,
  parameter logic [7:0]  START_CHAR    = 8'h52,
  parameter logic [7:0]  TERM_CHAR     = 8'h0D,
  parameter int          TIMEOUT_TICKS = 2048
) (
  input logic                clk_in_i,
  input logic                reset_i,
  sens_frame_parser_if.slave bus
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int ACC_W = DATA_W + 4;
  localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_TERM  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [CNT_W-1:0]  dcnt, dcnt_n;
  logic [TMR_W-1:0]  tmr, tmr_n;
  logic              sat_flag, sat_n;
  logic              err_n;
  logic              err_q;
  logic              sat_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        frame_cnt_q;

  logic              is_digit;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_over;

  // Decimal step: acc*10 + digit. acc never exceeds ACC_MAX, so the four spare
  // bits hold the product without wrapping and the compare detects overflow.
  always_comb begin
    is_digit = (bus.byte_i >= 8'h30) && (bus.byte_i <= 8'h39);
    acc_sum  = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, bus.byte_i[3:0]};
    acc_over = (acc_sum > ACC_MAX);
  end

  // Next-state and datapath control; the byte strobe takes priority over a timeout.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    dcnt_n  = dcnt;
    tmr_n   = tmr;
    sat_n   = sat_flag;
    err_n   = 1'b0;
    case (state)
      S_IDLE, S_WRITE: begin
        state_n = S_IDLE;
        if (bus.byte_vld_i && bus.byte_i == START_CHAR) begin
          state_n = S_DIGIT;
          acc_n   = '0;
          dcnt_n  = '0;
          tmr_n   = '0;
          sat_n   = 1'b0;
        end
      end
      S_DIGIT, S_TERM: begin
        if (bus.byte_vld_i) begin
          tmr_n = '0;
          if (state == S_DIGIT && is_digit) begin
            acc_n  = acc_over ? ACC_MAX : acc_sum;
            sat_n  = sat_flag | acc_over;
            dcnt_n = dcnt + CNT_W'(1);
            if (dcnt == CNT_W'(DIGITS - 1)) state_n = S_TERM;
          end else if (bus.byte_i == TERM_CHAR) begin
            if (state == S_TERM || dcnt != '0) begin
              state_n = S_WRITE;
            end else begin
              err_n   = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            err_n = 1'b1;
            if (bus.byte_i == START_CHAR) begin
              state_n = S_DIGIT;
              acc_n   = '0;
              dcnt_n  = '0;
              sat_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
            end
          end
        end else if (bus.clk_en_i) begin
          if (tmr == TMR_W'(TIMEOUT_TICKS - 1)) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr + TMR_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Parser state, accumulator, digit counter and inter-byte timer.
  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= S_IDLE;
      acc      <= '0;
      dcnt     <= '0;
      tmr      <= '0;
      sat_flag <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      dcnt     <= dcnt_n;
      tmr      <= tmr_n;
      sat_flag <= sat_n;
      err_q    <= err_n;
    end
  end

  // Output value, saturation flag and frame count are captured on entry to WRITE
  // so they are already valid in the cycle the write strobe is high.
  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      data_q      <= '0;
      sat_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else if (state_n == S_WRITE) begin
      data_q      <= acc[DATA_W-1:0];
      sat_q       <= sat_flag;
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign bus.sens_data_o       = data_q;
  assign bus.sens_addr_o       = ADDR_W'(MEM_ADDR);
  assign bus.sens_write_data_o = (state == S_WRITE);
  assign bus.sat_o             = sat_q;
  assign bus.err_o             = err_q;
  assign bus.frame_cnt_o       = frame_cnt_q;
  assign bus.state_dbg_o       = state;

  // Unused upper accumulator bits are always zero after clamping.
  logic unused_acc;
  assign unused_acc = ^acc[ACC_W-1:DATA_W];

endmodule

// File: tb/tb_sens_frame_parser.sv
// Bench for sens_frame_parser: two instances (16-bit and 8-bit data) share one
// byte stream; expected writes are queued per instance and checked on output.
module tb_sens_frame_parser;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_X  = 8'h58;

  logic clk;
  logic rst_n;
  logic [7:0] drv_byte;
  logic drv_vld;
  logic drv_en;

  int checks;
  int failures;
  int exp_cnt;
  int last_a;

  logic [16:0] exp_qa[$];
  logic [8:0]  exp_qb[$];

  sens_frame_parser_if #(.DATA_W(16), .ADDR_W(8)) if_a();
  sens_frame_parser_if #(.DATA_W(8),  .ADDR_W(8)) if_b();

  assign if_a.byte_i     = drv_byte;
  assign if_a.byte_vld_i = drv_vld;
  assign if_a.clk_en_i   = drv_en;
  assign if_b.byte_i     = drv_byte;
  assign if_b.byte_vld_i = drv_vld;
  assign if_b.clk_en_i   = drv_en;

  sens_frame_parser #(.DATA_W(16), .TIMEOUT_TICKS(2048)) dut_a (
    .clk_in_i (clk),
    .reset_i  (rst_n),
    .bus      (if_a)
  );

  sens_frame_parser #(.DATA_W(8), .TIMEOUT_TICKS(16)) dut_b (
    .clk_in_i (clk),
    .reset_i  (rst_n),
    .bus      (if_b)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver: one strobe, then check write/err one cycle after it.
  task automatic send_byte(input logic [7:0] b, input logic exp_wr, input logic exp_err);
    @(negedge clk);
    drv_byte = b;
    drv_vld  = 1'b1;
    @(negedge clk);
    drv_vld  = 1'b0;
    check_eq("wr_a",  32'(if_a.sens_write_data_o), 32'(exp_wr));
    check_eq("wr_b",  32'(if_b.sens_write_data_o), 32'(exp_wr));
    check_eq("err_a", 32'(if_a.err_o), 32'(exp_err));
    check_eq("err_b", 32'(if_b.err_o), 32'(exp_err));
  endtask

  // Back-to-back strobes, no per-byte checks (outputs go through the scoreboard).
  task automatic send_burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    logic [7:0] seq [6];
    seq = '{b0, b1, b2, b3, b4, b5};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv_byte = seq[i];
      drv_vld  = 1'b1;
    end
    @(negedge clk);
    drv_vld = 1'b0;
  endtask

  task automatic push_exp(input int val);
    int vb;
    logic sb;
    sb = (val > 255);
    vb = sb ? 255 : val;
    exp_qa.push_back({1'b0, 16'(val)});
    exp_qb.push_back({sb, 8'(vb)});
    exp_cnt++;
    last_a = val;
  endtask

  // Scoreboard: every write strobe must match the head of its queue.
  always @(negedge clk) begin
    logic [16:0] ea;
    if (if_a.sens_write_data_o) begin
      if (exp_qa.size() == 0) check_eq("unexpected_wr_a", 32'd1, 32'd0);
      else begin
        ea = exp_qa.pop_front();
        check_eq("data_a", 32'(if_a.sens_data_o), 32'(ea[15:0]));
        check_eq("sat_a",  32'(if_a.sat_o), 32'(ea[16]));
        check_eq("addr_a", 32'(if_a.sens_addr_o), 32'd13);
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] eb;
    if (if_b.sens_write_data_o) begin
      if (exp_qb.size() == 0) check_eq("unexpected_wr_b", 32'd1, 32'd0);
      else begin
        eb = exp_qb.pop_front();
        check_eq("data_b", 32'(if_b.sens_data_o), 32'(eb[7:0]));
        check_eq("sat_b",  32'(if_b.sat_o), 32'(eb[8]));
      end
    end
  end

  initial begin
    int n, val, dig, na, nb;
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    last_a   = 0;
    drv_byte = 8'h00;
    drv_vld  = 1'b0;
    drv_en   = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_data_a", 32'(if_a.sens_data_o), 32'd0);
    check_eq("rst_wr_a",   32'(if_a.sens_write_data_o), 32'd0);
    check_eq("rst_sat_a",  32'(if_a.sat_o), 32'd0);
    check_eq("rst_err_a",  32'(if_a.err_o), 32'd0);
    check_eq("rst_cnt_a",  32'(if_a.frame_cnt_o), 32'd0);
    check_eq("rst_addr_a", 32'(if_a.sens_addr_o), 32'd13);
    check_eq("rst_state_a", 32'(if_a.state_dbg_o), 32'd0);
    check_eq("rst_data_b", 32'(if_b.sens_data_o), 32'd0);

    // R123 CR
    send_byte(CH_R, 0, 0);
    send_byte("1", 0, 0);
    send_byte("2", 0, 0);
    send_byte("3", 0, 0);
    push_exp(123);
    send_byte(CH_CR, 1, 0);
    check_eq("cnt_after_first", 32'(if_a.frame_cnt_o), 32'd1);

    // R7 CR
    send_byte(CH_R, 0, 0);
    send_byte("7", 0, 0);
    push_exp(7);
    send_byte(CH_CR, 1, 0);

    // Bad byte mid-frame, then a good frame
    send_byte(CH_R, 0, 0);
    send_byte("1", 0, 0);
    send_byte(CH_X, 0, 1);
    check_eq("state_after_x", 32'(if_a.state_dbg_o), 32'd0);
    send_byte(CH_R, 0, 0);
    send_byte("5", 0, 0);
    push_exp(5);
    send_byte(CH_CR, 1, 0);

    // Saturation on the 8-bit instance, flag held, then cleared by next write
    send_byte(CH_R, 0, 0);
    send_byte("9", 0, 0);
    send_byte("9", 0, 0);
    send_byte("9", 0, 0);
    push_exp(999);
    send_byte(CH_CR, 1, 0);
    repeat (5) @(negedge clk);
    check_eq("sat_hold_b", 32'(if_b.sat_o), 32'd1);
    check_eq("data_hold_b", 32'(if_b.sens_data_o), 32'd255);
    send_byte(CH_R, 0, 0);
    send_byte("1", 0, 0);
    push_exp(1);
    send_byte(CH_CR, 1, 0);

    // Too many digits, empty frame, restart on R mid-frame
    send_byte(CH_R, 0, 0);
    send_byte("1", 0, 0);
    send_byte("2", 0, 0);
    send_byte("3", 0, 0);
    send_byte("4", 0, 1);
    send_byte(CH_R, 0, 0);
    send_byte(CH_CR, 0, 1);
    send_byte(CH_R, 0, 0);
    send_byte("1", 0, 0);
    send_byte(CH_R, 0, 1);
    send_byte("2", 0, 0);
    push_exp(2);
    send_byte(CH_CR, 1, 0);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 3);
      val = 0;
      send_byte(CH_R, 0, 0);
      for (int d = 0; d < n; d++) begin
        dig = $urandom_range(0, 9);
        val = val * 10 + dig;
        send_byte(8'h30 + 8'(dig), 0, 0);
      end
      push_exp(val);
      send_byte(CH_CR, 1, 0);
    end

    // Back-to-back frames; second start byte lands in the WRITE cycle
    push_exp(8);
    push_exp(6);
    send_burst(CH_R, "8", CH_CR, CH_R, "6", CH_CR);
    repeat (2) @(negedge clk);

    // Timeout: 16 ticks on dut_b, 2048 ticks on dut_a
    send_byte(CH_R, 0, 0);
    send_byte("4", 0, 0);
    na = 0;
    nb = 0;
    for (int i = 1; i <= 2200; i++) begin
      @(negedge clk);
      if (if_b.err_o && nb == 0) nb = i;
      if (if_a.err_o) begin
        na = i;
        break;
      end
    end
    check_eq("timeout_b_ticks", 32'(nb), 32'd16);
    check_eq("timeout_a_ticks", 32'(na), 32'd2048);
    @(negedge clk);
    check_eq("timeout_state_a", 32'(if_a.state_dbg_o), 32'd0);
    check_eq("timeout_state_b", 32'(if_b.state_dbg_o), 32'd0);
    check_eq("timeout_data_a", 32'(if_a.sens_data_o), 32'(last_a));
    check_eq("cnt_before_reset", 32'(if_a.frame_cnt_o), 32'(exp_cnt % 256));

    // Reset mid-frame discards the partial frame
    send_byte(CH_R, 0, 0);
    send_byte("1", 0, 0);
    send_byte("2", 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    send_byte("3", 0, 0);
    send_byte(CH_CR, 0, 0);
    check_eq("cnt_after_reset_a", 32'(if_a.frame_cnt_o), 32'd0);
    check_eq("cnt_after_reset_b", 32'(if_b.frame_cnt_o), 32'd0);
    check_eq("data_after_reset_a", 32'(if_a.sens_data_o), 32'd0);

    send_byte(CH_R, 0, 0);
    send_byte("4", 0, 0);
    send_byte("2", 0, 0);
    push_exp(42);
    send_byte(CH_CR, 1, 0);
    check_eq("cnt_final_a", 32'(if_a.frame_cnt_o), 32'(exp_cnt));

    repeat (3) @(negedge clk);
    check_eq("queue_empty_a", 32'(exp_qa.size()), 32'd0);
    check_eq("queue_empty_b", 32'(exp_qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
